// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the system-ID slave (word 0 = ID, word 1 = build
// timestamp), compares both against build-time constants and reports status.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h11223344,
    parameter logic [31:0] EXPECTED_TS    = 32'h56FA7A44,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE} state_t;

    localparam logic [1:0]  LAT_LAST = 2'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);
    localparam logic [15:0] TO_LAST  = 16'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        auto_q, auto_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  lat_q, lat_d;
    logic        read_q, read_d;
    logic        addr_q, addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic        id_cap_q, id_cap_d;
    logic        ts_cap_q, ts_cap_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;

    logic accept, capture, in_phase, is_ts;

    always_comb begin
        state_d    = state_q;
        auto_d     = auto_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        read_d     = read_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = done_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        id_cap_d   = id_cap_q;
        ts_cap_d   = ts_cap_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        capture    = 1'b0;
        accept     = read_q & ~avm_waitrequest;
        in_phase   = (state_q == RD_ID) || (state_q == LAT_ID) ||
                     (state_q == RD_TS) || (state_q == LAT_TS);
        is_ts      = (state_q == RD_TS) || (state_q == LAT_TS);

        case (state_q)
            IDLE, DONE: begin
                // DONE is entered one cycle before the registered compares land
                if (state_q == DONE && !done_q) begin
                    id_ok_d = id_cap_q && (id_value_q == EXPECTED_ID);
                    ts_ok_d = ts_cap_q && (ts_value_q == EXPECTED_TS);
                    pass_d  = id_ok_d && ts_ok_d && !timeout_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (start || (state_q == IDLE && auto_q)) begin
                    state_d   = RD_ID;
                    auto_d    = 1'b0;
                    read_d    = 1'b1;
                    addr_d    = 1'b0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    id_cap_d  = 1'b0;
                    ts_cap_d  = 1'b0;
                    cnt_d     = '0;
                end
            end
            RD_ID, RD_TS: begin
                if (accept) begin
                    read_d = 1'b0;
                    if (READ_LATENCY == 0) begin
                        capture = 1'b1;
                    end else begin
                        lat_d   = '0;
                        state_d = is_ts ? LAT_TS : LAT_ID;
                    end
                end
            end
            LAT_ID, LAT_TS: begin
                if (lat_q == LAT_LAST) capture = 1'b1;
                else                   lat_d   = lat_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            if (is_ts) begin
                ts_value_d = avm_readdata;
                ts_cap_d   = 1'b1;
                read_d     = 1'b0;
                state_d    = DONE;
            end else begin
                id_value_d = avm_readdata;
                id_cap_d   = 1'b1;
                read_d     = 1'b1;
                addr_d     = 1'b1;
                cnt_d      = '0;
                state_d    = RD_TS;
            end
        end else if (in_phase && TIMEOUT_CYCLES != 0) begin
            if (cnt_q == TO_LAST) begin
                read_d    = 1'b0;
                timeout_d = 1'b1;
                state_d   = DONE;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            auto_q     <= AUTO_START;
            cnt_q      <= '0;
            lat_q      <= '0;
            read_q     <= 1'b0;
            addr_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            id_cap_q   <= 1'b0;
            ts_cap_q   <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            state_q    <= state_d;
            auto_q     <= auto_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            id_cap_q   <= id_cap_d;
            ts_cap_q   <= ts_cap_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end

    assign avm_read    = read_q;
    assign avm_address = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Avalon-MM master that sits directly upstream of the system-ID slave and consumes its output.
- Reads word 0 (system ID) and word 1 (build timestamp) from the slave and compares both against values fixed at build time.
- Raises pass/fail/timeout status so boot logic, or a status LED, can refuse to run on a mismatched hardware image.
- Runs once automatically after reset, and again on every start request.

Parameters:
- EXPECTED_ID, 32'h11223344, system ID required at slave address 0.
- EXPECTED_TS, 32'h56FA7A44, timestamp required at slave address 1.
- READ_LATENCY, 0, fixed slave read latency in cycles after read is accepted; legal range 0..3.
- TIMEOUT_CYCLES, 255, maximum cycles per read phase; 0 disables the timeout; legal range 0..65535.
- AUTO_START, 1, when 1 a check launches on the first cycle after reset deasserts.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to run a check
- avm_address  out  1  slave word address: 0 = ID, 1 = timestamp
- avm_read  out  1  Avalon read strobe
- avm_waitrequest  in  1  slave stall; tie to 0 for a zero-wait slave
- avm_readdata  in  32  slave read data
- busy  out  1  check in progress
- done  out  1  check finished; sticky
- id_ok  out  1  captured ID equals EXPECTED_ID
- ts_ok  out  1  captured timestamp equals EXPECTED_TS
- pass  out  1  done & id_ok & ts_ok & ~timeout
- timeout  out  1  a read phase exceeded TIMEOUT_CYCLES
- id_value  out  32  last captured ID word
- ts_value  out  32  last captured timestamp word

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high; the ports are named clock and reset.
  - All outputs are registered.
  - Reset values: avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, pass=0, timeout=0, id_value=0, ts_value=0. State returns to IDLE.
- States: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE.
- IDLE:
  - Moves to RD_ID when start=1, or on the first cycle out of reset if AUTO_START=1.
  - On entry to RD_ID: done, id_ok, ts_ok, pass and timeout are cleared; busy=1.
- RD_ID:
  - Drives avm_read=1 and avm_address=0.
  - Both are held stable while avm_waitrequest=1.
  - The read is accepted on the first cycle with avm_read & ~avm_waitrequest.
- Accept in RD_ID:
  - avm_read drops on the next cycle.
  - If READ_LATENCY=0, avm_readdata is captured into id_value on the accept cycle, then the state moves to RD_TS.
  - Otherwise the state moves to LAT_ID, counts READ_LATENCY cycles, and captures on the final count cycle (the Nth cycle after accept), then moves to RD_TS.
- RD_TS / LAT_TS: identical to RD_ID / LAT_ID, with address 1 and capture into ts_value. They then move to DONE.
- DONE:
  - busy=0 and done=1.
  - id_ok and ts_ok are registered compares of the captured words.
  - pass is valid in the same cycle that done rises.
  - All results hold until the next start.
- Latency: with waitrequest tied to 0 and READ_LATENCY=0, start is sampled at edge k, and done and pass are high in cycle k+3. Each unit of READ_LATENCY adds 2 cycles; each waitrequest stall cycle adds 1.
- Timeout:
  - A per-phase counter is zeroed on entry to RD_ID and on entry to RD_TS.
  - It increments on every cycle in RD_x/LAT_x that has no capture.
  - If it reaches TIMEOUT_CYCLES with no capture that cycle, the block deasserts avm_read next cycle and enters DONE with timeout=1 and pass=0.
  - On a timeout in the ID phase, id_ok=0 and ts_ok=0, and ts_value retains its old value.
- Simultaneous events:
  - start while busy is ignored.
  - start in DONE restarts the check; results clear on entry to RD_ID.
  - start in the same cycle as reset is ignored; reset wins.
- Reset mid-operation: at the reset edge the block aborts immediately, with avm_read=0 in the next cycle and no further captures. If AUTO_START=1 a fresh check follows.
- Compare rules: full 32-bit equality with no masking. Captured words are exposed unmodified for software readback.

Test Plan:
- Zero-wait slave returning 32'h11223344 and 32'h56FA7A44, AUTO_START=1: release reset -> avm_read high for 2 cycles with address 0 then 1; done=1, pass=1, id_ok=ts_ok=1 exactly 3 cycles after reset release.
- Slave returns ID 32'h11223345: -> done=1, id_ok=0, ts_ok=1, pass=0, id_value=32'h11223345.
- Waitrequest held high for 5 cycles on each read: -> avm_read and avm_address stable throughout the stall; pass=1 at cycle 3+10 after start.
- READ_LATENCY=2 with data valid 2 cycles after accept: -> correct capture, pass=1 at cycle 7 after start; data presented 1 cycle early -> mismatch, pass=0.
- TIMEOUT_CYCLES=8, waitrequest stuck at 1: -> avm_read drops after 8 cycles; done=1, timeout=1, pass=0, busy=0; later start with waitrequest=0 -> pass=1, timeout=0.
- Reset asserted during RD_TS, and start pulsed while busy: -> avm_read=0 the cycle after reset, then a fresh auto-check runs; the mid-check start produces no second run and no extra read.
